aes_mem_arbiter: RTL and testbench

//  Parametrised multi-requester front end for the AES scratch memory (aes_mem).

---
 rtl/aes_mem_arbiter_pkg.sv | 31 +++
 rtl/aes_mem_arbiter_if.sv | 38 +++
 rtl/aes_mem_arbiter_rr_arbiter.sv | 62 ++++++
 rtl/aes_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_aes_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_mem_arbiter_pkg.sv
// Shared types and helpers for the AES scratch-memory arbiter.
package aes_mem_arbiter_pkg;

   localparam int AES_DATA_W = 32;
   localparam int AES_ADDR_W = 10;
   localparam int MAX_REQ    = 16;
   localparam int REQ_IDX_W  = 4;

   typedef logic [REQ_IDX_W-1:0] req_idx_t;

   // Lock ownership state: nobody owns the ports, or one requester owns both.
   typedef enum logic [0:0] {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   // Index of the set bit of a one-hot vector (0 when the vector is empty).
   function automatic req_idx_t onehot2idx(input logic [MAX_REQ-1:0] onehot);
      req_idx_t idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (onehot[i]) begin
            idx = idx | req_idx_t'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/aes_mem_arbiter_if.sv
// Requester-side and memory-side bus of the AES scratch-memory arbiter.
interface aes_mem_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10
);
   localparam int BE_W = DATA_W / 8;

   logic [NUM_REQ-1:0]        req_in;
   logic [NUM_REQ-1:0]        wr_in;
   logic [NUM_REQ-1:0]        lock_in;
   logic [NUM_REQ*ADDR_W-1:0] addr_in;
   logic [NUM_REQ*DATA_W-1:0] wdata_in;
   logic [NUM_REQ*BE_W-1:0]   be_in;
   logic [NUM_REQ-1:0]        gnt_out;
   logic [NUM_REQ-1:0]        rvalid_out;
   logic [DATA_W-1:0]         rdata_out;
   logic [NUM_REQ-1:0]        owner_out;
   logic [ADDR_W-1:0]         mem_rd_addr_out;
   logic [ADDR_W-1:0]         mem_wr_addr_out;
   logic [BE_W-1:0]           mem_we_out;
   logic [DATA_W-1:0]         mem_wdata_out;
   logic [DATA_W-1:0]         mem_rdata_in;

   // Requesters and the memory model sit on this side.
   modport master (
      output req_in, wr_in, lock_in, addr_in, wdata_in, be_in, mem_rdata_in,
      input  gnt_out, rvalid_out, rdata_out, owner_out,
             mem_rd_addr_out, mem_wr_addr_out, mem_we_out, mem_wdata_out
   );

   // The arbiter sits on this side.
   modport slave (
      input  req_in, wr_in, lock_in, addr_in, wdata_in, be_in, mem_rdata_in,
      output gnt_out, rvalid_out, rdata_out, owner_out,
             mem_rd_addr_out, mem_wr_addr_out, mem_we_out, mem_wdata_out
   );
endinterface

// File: rtl/aes_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker with optional fixed host priority.
module aes_rr_arbiter
   import aes_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter bit HOST_PRIO = 1'b0
) (
   input  logic [NUM_REQ-1:0] elig,
   input  req_idx_t           ptr,
   output logic [NUM_REQ-1:0] gnt,
   output req_idx_t           ptr_nxt
);
   logic               found_v;
   int                 dist_v;
   logic [MAX_REQ-1:0] gnt_ext_s;
   req_idx_t           gnt_idx_s;

   // Pick the eligible requester closest to the pointer; the host jumps the queue when prioritised.
   always_comb begin
      gnt     = '0;
      found_v = 1'b0;
      dist_v  = 0;
      if (HOST_PRIO && elig[0]) begin
         gnt[0]  = 1'b1;
         found_v = 1'b1;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               dist_v = i - int'(ptr);
               if (dist_v < 0) begin
                  dist_v = dist_v + NUM_REQ;
               end else begin
                  dist_v = dist_v;
               end
               if (!found_v && elig[i] && (dist_v == k)) begin
                  gnt[i]  = 1'b1;
                  found_v = 1'b1;
               end else begin
                  found_v = found_v;
               end
            end
         end
      end
   end

   // Advance past the winner; prioritised host grants leave the rotation untouched.
   always_comb begin
      gnt_ext_s                = '0;
      gnt_ext_s[NUM_REQ-1:0]   = gnt;
      gnt_idx_s                = onehot2idx(gnt_ext_s);
      if ((|gnt) && !(HOST_PRIO && gnt[0])) begin
         if (gnt_idx_s == req_idx_t'(NUM_REQ - 1)) begin
            ptr_nxt = '0;
         end else begin
            ptr_nxt = gnt_idx_s + req_idx_t'(1);
         end
      end else begin
         ptr_nxt = ptr;
      end
   end

endmodule

// File: rtl/aes_mem_arbiter.sv
// Multi-requester front end for the AES scratch memory: independent read/write
// round-robin ports, an ownership lock, and a tagged read-return pipeline.
module aes_mem_arbiter
   import aes_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int DATA_W    = AES_DATA_W,
   parameter int ADDR_W    = AES_ADDR_W,
   parameter int RD_LAT    = 2,
   parameter bit HOST_PRIO = 1'b0
) (
   input logic              clk_in,
   input logic              rst_n_in,
   aes_mem_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;

   lock_state_e        lock_state_r, lock_state_nxt_s;
   logic [NUM_REQ-1:0] owner_r, owner_nxt_s;
   logic [NUM_REQ-1:0] elig_mask_s, rd_cand_s, wr_cand_s;
   logic [NUM_REQ-1:0] rd_gnt_s, wr_gnt_s, lock_gnt_s, lock_pick_s;
   req_idx_t           rd_ptr_r, rd_ptr_nxt_s, wr_ptr_r, wr_ptr_nxt_s;
   logic [ADDR_W-1:0]  rd_addr_sel_s, rd_addr_hold_r, wr_addr_sel_s;
   logic [DATA_W-1:0]  wdata_sel_s;
   logic [BE_W-1:0]    be_sel_s;
   logic [NUM_REQ-1:0] tag_r [RD_LAT];

   // Grants are combinational, so they are also suppressed while reset is held.
   assign rd_cand_s = bus.req_in & ~bus.wr_in & elig_mask_s & {NUM_REQ{rst_n_in}};
   assign wr_cand_s = bus.req_in &  bus.wr_in & elig_mask_s & {NUM_REQ{rst_n_in}};

   aes_rr_arbiter #(.NUM_REQ(NUM_REQ), .HOST_PRIO(HOST_PRIO)) u_rd_arb (
      .elig(rd_cand_s), .ptr(rd_ptr_r), .gnt(rd_gnt_s), .ptr_nxt(rd_ptr_nxt_s)
   );

   aes_rr_arbiter #(.NUM_REQ(NUM_REQ), .HOST_PRIO(HOST_PRIO)) u_wr_arb (
      .elig(wr_cand_s), .ptr(wr_ptr_r), .gnt(wr_gnt_s), .ptr_nxt(wr_ptr_nxt_s)
   );

   // If read and write grants both ask for the lock, the lower index takes it.
   assign lock_gnt_s  = (rd_gnt_s | wr_gnt_s) & bus.lock_in;
   assign lock_pick_s = lock_gnt_s & (~lock_gnt_s + NUM_REQ'(1'b1));

   // Lock state and owner register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         lock_state_r <= LOCK_IDLE;
         owner_r      <= '0;
      end else begin
         lock_state_r <= lock_state_nxt_s;
         owner_r      <= owner_nxt_s;
      end
   end

   // Take the lock on a locking grant; release when the owner stops locking or stops requesting.
   always_comb begin
      lock_state_nxt_s = lock_state_r;
      owner_nxt_s      = owner_r;
      case (lock_state_r)
         LOCK_IDLE: begin
            if (|lock_pick_s) begin
               lock_state_nxt_s = LOCK_HELD;
               owner_nxt_s      = lock_pick_s;
            end else begin
               lock_state_nxt_s = LOCK_IDLE;
               owner_nxt_s      = '0;
            end
         end
         LOCK_HELD: begin
            if (((owner_r & bus.req_in) == '0) || ((owner_r & bus.lock_in) == '0)) begin
               lock_state_nxt_s = LOCK_IDLE;
               owner_nxt_s      = '0;
            end else begin
               lock_state_nxt_s = LOCK_HELD;
               owner_nxt_s      = owner_r;
            end
         end
         default: begin
            lock_state_nxt_s = LOCK_IDLE;
            owner_nxt_s      = '0;
         end
      endcase
   end

   // While locked only the owner may compete on either port.
   always_comb begin
      elig_mask_s = {NUM_REQ{1'b1}};
      case (lock_state_r)
         LOCK_IDLE: elig_mask_s = {NUM_REQ{1'b1}};
         LOCK_HELD: elig_mask_s = owner_r;
         default:   elig_mask_s = {NUM_REQ{1'b1}};
      endcase
   end

   // One-hot grants make an OR-mux sufficient for the selected lane.
   always_comb begin
      rd_addr_sel_s = '0;
      wr_addr_sel_s = '0;
      wdata_sel_s   = '0;
      be_sel_s      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_addr_sel_s = rd_addr_sel_s | ({ADDR_W{rd_gnt_s[i]}} & bus.addr_in[i*ADDR_W +: ADDR_W]);
         wr_addr_sel_s = wr_addr_sel_s | ({ADDR_W{wr_gnt_s[i]}} & bus.addr_in[i*ADDR_W +: ADDR_W]);
         wdata_sel_s   = wdata_sel_s   | ({DATA_W{wr_gnt_s[i]}} & bus.wdata_in[i*DATA_W +: DATA_W]);
         be_sel_s      = be_sel_s      | ({BE_W{wr_gnt_s[i]}}   & bus.be_in[i*BE_W +: BE_W]);
      end
   end

   // Round-robin pointers and the read address held across idle cycles.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_ptr_r       <= '0;
         wr_ptr_r       <= '0;
         rd_addr_hold_r <= '0;
      end else begin
         rd_ptr_r       <= rd_ptr_nxt_s;
         wr_ptr_r       <= wr_ptr_nxt_s;
         rd_addr_hold_r <= bus.mem_rd_addr_out;
      end
   end

   // Read tags travel alongside the RAM latency; one slot per stage so tags never collide.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int j = 0; j < RD_LAT; j++) begin
            tag_r[j] <= '0;
         end
      end else begin
         tag_r[0] <= rd_gnt_s;
         for (int j = 1; j < RD_LAT; j++) begin
            tag_r[j] <= tag_r[j-1];
         end
      end
   end

   assign bus.gnt_out         = rd_gnt_s | wr_gnt_s;
   assign bus.owner_out       = owner_r;
   assign bus.rvalid_out      = tag_r[RD_LAT-1];
   assign bus.rdata_out       = rst_n_in ? bus.mem_rdata_in : '0;
   assign bus.mem_rd_addr_out = (|rd_gnt_s) ? rd_addr_sel_s : rd_addr_hold_r;
   assign bus.mem_wr_addr_out = wr_addr_sel_s;
   assign bus.mem_wdata_out   = wdata_sel_s;
   assign bus.mem_we_out      = be_sel_s;

endmodule

// File: tb/tb_aes_mem_arbiter.sv
// Directed bench for aes_mem_arbiter: round-robin instance with a read-first
// RAM model, plus a host-priority instance for the priority scenario.
module tb_aes_mem_arbiter;

   logic clk;
   logic rst_n;
   logic mem_init;
   int   n_checks;
   int   n_errors;

   aes_mem_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(10)) bus0 ();
   aes_mem_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(10)) bus1 ();

   aes_mem_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(10), .RD_LAT(2), .HOST_PRIO(1'b0)) dut0 (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus0)
   );

   aes_mem_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(10), .RD_LAT(2), .HOST_PRIO(1'b1)) dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus1)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first RAM model with two-cycle read latency and byte enables.
   logic [31:0] mem_m [64];
   logic [31:0] q1_r, q2_r;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int j = 0; j < 64; j++) mem_m[j] <= 32'h0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (bus0.mem_we_out[b]) mem_m[bus0.mem_wr_addr_out[5:0]][b*8 +: 8] <= bus0.mem_wdata_out[b*8 +: 8];
         end
      end
      q1_r <= mem_m[bus0.mem_rd_addr_out[5:0]];
      q2_r <= q1_r;
   end
   assign bus0.mem_rdata_in = q2_r;
   assign bus1.mem_rdata_in = 32'h0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_all();
      bus0.req_in = 3'b000; bus0.wr_in = 3'b000; bus0.lock_in = 3'b000;
      bus0.addr_in = 30'h0; bus0.wdata_in = 96'h0; bus0.be_in = 12'h0;
      bus1.req_in = 3'b000; bus1.wr_in = 3'b000; bus1.lock_in = 3'b000;
      bus1.addr_in = 30'h0; bus1.wdata_in = 96'h0; bus1.be_in = 12'h0;
   endtask

   task automatic drv0(input int i, input logic rq, input logic w, input logic lk,
                       input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      bus0.req_in[i]            = rq;
      bus0.wr_in[i]             = w;
      bus0.lock_in[i]           = lk;
      bus0.addr_in[i*10 +: 10]  = a;
      bus0.wdata_in[i*32 +: 32] = d;
      bus0.be_in[i*4 +: 4]      = be;
   endtask

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] host_pat;
      logic [2:0] eng_exp;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      mem_init = 1'b1;
      clr_all();

      // Reset held with random traffic: nothing may be granted or owned.
      for (int c = 0; c < 3; c++) begin
         bus0.req_in = 3'($urandom); bus0.wr_in = 3'($urandom); bus0.lock_in = 3'($urandom);
         bus0.addr_in = 30'($urandom); bus0.be_in = 12'($urandom);
         bus1.req_in = 3'($urandom); bus1.wr_in = 3'($urandom); bus1.lock_in = 3'($urandom);
         #2;
         check_val("rst_gnt0", bus0.gnt_out, 3'b000);
         check_val("rst_rvalid0", bus0.rvalid_out, 3'b000);
         check_val("rst_we0", bus0.mem_we_out, 4'h0);
         check_val("rst_owner0", bus0.owner_out, 3'b000);
         check_val("rst_gnt1", bus1.gnt_out, 3'b000);
         cyc();
      end
      clr_all();
      mem_init = 1'b0;
      rst_n    = 1'b1;
      #2;
      check_val("post_rst_rdaddr", bus0.mem_rd_addr_out, 10'h000);
      check_val("post_rst_owner", bus0.owner_out, 3'b000);
      cyc();

      // Host write then read of 0x005.
      drv0(0, 1'b1, 1'b1, 1'b0, 10'h005, 32'hDEADBEEF, 4'hF);
      #2;
      check_val("t2_wr_gnt", bus0.gnt_out, 3'b001);
      check_val("t2_we", bus0.mem_we_out, 4'hF);
      check_val("t2_wr_addr", bus0.mem_wr_addr_out, 10'h005);
      check_val("t2_wdata", bus0.mem_wdata_out, 32'hDEADBEEF);
      cyc();
      clr_all();
      drv0(0, 1'b1, 1'b0, 1'b0, 10'h005, 32'h0, 4'h0);
      #2;
      check_val("t2_rd_gnt", bus0.gnt_out, 3'b001);
      check_val("t2_rd_addr", bus0.mem_rd_addr_out, 10'h005);
      check_val("t2_rd_we", bus0.mem_we_out, 4'h0);
      cyc();
      clr_all();
      #2;
      check_val("t2_rvalid_early", bus0.rvalid_out, 3'b000);
      check_val("t2_addr_hold", bus0.mem_rd_addr_out, 10'h005);
      check_val("t2_idle_gnt", bus0.gnt_out, 3'b000);
      cyc();
      #2;
      check_val("t2_rvalid", bus0.rvalid_out, 3'b001);
      check_val("t2_rdata", bus0.rdata_out, 32'hDEADBEEF);
      cyc();
      #2;
      check_val("t2_rvalid_off", bus0.rvalid_out, 3'b000);
      cyc();

      // Two reads in flight when reset hits: their tags must vanish.
      drv0(0, 1'b1, 1'b0, 1'b0, 10'h005, 32'h0, 4'h0);
      #2;
      check_val("t1b_gnt_a", bus0.gnt_out, 3'b001);
      cyc();
      #2;
      check_val("t1b_gnt_b", bus0.gnt_out, 3'b001);
      cyc();
      rst_n = 1'b0;
      clr_all();
      #2;
      check_val("t1b_rvalid_rst", bus0.rvalid_out, 3'b000);
      cyc();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         check_val("t1b_rvalid_after", bus0.rvalid_out, 3'b000);
         cyc();
      end

      // All three read continuously: grants rotate 0,1,2 and tags follow in order.
      for (int k = 0; k < 9; k++) begin
         clr_all();
         if (k < 6) begin
            drv0(0, 1'b1, 1'b0, 1'b0, 10'h005, 32'h0, 4'h0);
            drv0(1, 1'b1, 1'b0, 1'b0, 10'h006, 32'h0, 4'h0);
            drv0(2, 1'b1, 1'b0, 1'b0, 10'h007, 32'h0, 4'h0);
         end
         #2;
         if (k < 6) check_val("t3_gnt", bus0.gnt_out, 3'b001 << (k % 3));
         else       check_val("t3_gnt_idle", bus0.gnt_out, 3'b000);
         if (k >= 2 && k < 8) begin
            check_val("t3_rvalid", bus0.rvalid_out, 3'b001 << ((k - 2) % 3));
            check_val("t3_rdata", bus0.rdata_out, (((k - 2) % 3) == 0) ? 32'hDEADBEEF : 32'h0);
         end
         if (k == 8) check_val("t3_rvalid_end", bus0.rvalid_out, 3'b000);
         cyc();
      end

      // Engine 1 locked write burst; host read blocked until the unlocking write.
      for (int k = 0; k < 6; k++) begin
         clr_all();
         if (k <= 4) drv0(1, 1'b1, 1'b1, (k < 4), 10'(48 + k), 32'hA000_0000 | 32'(k), 4'hF);
         if (k >= 1) drv0(0, 1'b1, 1'b0, 1'b0, 10'h005, 32'h0, 4'h0);
         #2;
         check_val("t4_gnt", bus0.gnt_out, (k <= 4) ? 3'b010 : 3'b001);
         check_val("t4_owner", bus0.owner_out, (k >= 1 && k <= 4) ? 3'b010 : 3'b000);
         if (k == 2) begin
            check_val("t4_wr_addr", bus0.mem_wr_addr_out, 10'h032);
            check_val("t4_wdata", bus0.mem_wdata_out, 32'hA000_0002);
         end
         cyc();
      end
      clr_all();
      cyc();
      #2;
      check_val("t4_rvalid", bus0.rvalid_out, 3'b001);
      check_val("t4_rdata", bus0.rdata_out, 32'hDEADBEEF);
      cyc();

      // Same-cycle read/write to 0x010 (read-first), then partial-byte write.
      drv0(2, 1'b1, 1'b1, 1'b0, 10'h010, 32'h1111_1111, 4'hF);
      drv0(0, 1'b1, 1'b0, 1'b0, 10'h010, 32'h0, 4'h0);
      #2;
      check_val("t5_gnt", bus0.gnt_out, 3'b101);
      check_val("t5_we", bus0.mem_we_out, 4'hF);
      check_val("t5_rd_addr", bus0.mem_rd_addr_out, 10'h010);
      check_val("t5_wr_addr", bus0.mem_wr_addr_out, 10'h010);
      cyc();
      clr_all();
      drv0(0, 1'b1, 1'b0, 1'b0, 10'h010, 32'h0, 4'h0);
      #2;
      check_val("t5_gnt_b", bus0.gnt_out, 3'b001);
      check_val("t5_we_b", bus0.mem_we_out, 4'h0);
      cyc();
      clr_all();
      drv0(0, 1'b1, 1'b0, 1'b0, 10'h033, 32'h0, 4'h0);
      drv0(1, 1'b1, 1'b1, 1'b0, 10'h010, 32'hAAAA_AAAA, 4'b0011);
      #2;
      check_val("t5_gnt_c", bus0.gnt_out, 3'b011);
      check_val("t5_we_c", bus0.mem_we_out, 4'b0011);
      check_val("t5_rvalid_old", bus0.rvalid_out, 3'b001);
      check_val("t5_rdata_old", bus0.rdata_out, 32'h0);
      cyc();
      clr_all();
      drv0(0, 1'b1, 1'b0, 1'b0, 10'h010, 32'h0, 4'h0);
      #2;
      check_val("t5_rdata_new", bus0.rdata_out, 32'h1111_1111);
      cyc();
      clr_all();
      #2;
      check_val("t5_rdata_burst", bus0.rdata_out, 32'hA000_0003);
      cyc();
      #2;
      check_val("t5_rvalid_be", bus0.rvalid_out, 3'b001);
      check_val("t5_rdata_be", bus0.rdata_out, 32'h1111_AAAA);
      cyc();
      #2;
      check_val("t5_rvalid_off", bus0.rvalid_out, 3'b000);
      cyc();

      // Owner releases the lock by dropping its request.
      drv0(2, 1'b1, 1'b0, 1'b1, 10'h010, 32'h0, 4'h0);
      #2;
      check_val("t7_gnt", bus0.gnt_out, 3'b100);
      cyc();
      clr_all();
      drv0(0, 1'b1, 1'b0, 1'b0, 10'h005, 32'h0, 4'h0);
      #2;
      check_val("t7_host_blocked", bus0.gnt_out, 3'b000);
      check_val("t7_owner", bus0.owner_out, 3'b100);
      cyc();
      #2;
      check_val("t7_host_gnt", bus0.gnt_out, 3'b001);
      check_val("t7_owner_clr", bus0.owner_out, 3'b000);
      check_val("t7_rvalid", bus0.rvalid_out, 3'b100);
      check_val("t7_rdata", bus0.rdata_out, 32'h1111_AAAA);
      cyc();
      clr_all();

      // Host priority: host wins whenever it asks, engines alternate otherwise.
      host_pat = 8'b0100_1011;
      eng_exp  = 3'b010;
      for (int k = 0; k < 8; k++) begin
         bus1.req_in  = {1'b1, 1'b1, host_pat[k]};
         bus1.wr_in   = 3'b000;
         bus1.lock_in = 3'b000;
         #2;
         if (host_pat[k]) begin
            check_val("t6_host", bus1.gnt_out, 3'b001);
         end else begin
            check_val("t6_engine", bus1.gnt_out, eng_exp);
            eng_exp = (eng_exp == 3'b010) ? 3'b100 : 3'b010;
         end
         cyc();
      end
      clr_all();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
